// File: rtl/writeback_stage.sv
// Writeback (W) stage of the Y86-style pipeline: W pipeline register, register-file write
// ports, machine run/halt/fault status and the retired-instruction counter.
module writeback_stage #(
    parameter int unsigned DATA_WID = 32,
    parameter int unsigned ADDR_WID = 4,
    parameter int unsigned CNT_WID  = 32,
    parameter logic [ADDR_WID-1:0] RNONE = ADDR_WID'(4'hF)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [2:0]          M_stat,
    input  logic [DATA_WID-1:0] M_valE,
    input  logic [DATA_WID-1:0] M_valM,
    input  logic [ADDR_WID-1:0] M_dstE,
    input  logic [ADDR_WID-1:0] M_dstM,
    input  logic                W_stall,
    input  logic                W_bubble,
    output logic [DATA_WID-1:0] valE,
    output logic [DATA_WID-1:0] valM,
    output logic [ADDR_WID-1:0] destE,
    output logic [ADDR_WID-1:0] destM,
    output logic [2:0]          W_stat,
    output logic                halted,
    output logic                fault,
    output logic [CNT_WID-1:0]  retired
);

    localparam logic [2:0] STAT_BUB = 3'd0;
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {StRun, StHalted, StFault} wbState_e;

    wbState_e            stateQ, stateD;
    logic [2:0]          statQ, statD;
    logic [DATA_WID-1:0] valEQ, valED, valMQ, valMD;
    logic [ADDR_WID-1:0] dstEQ, dstED, dstMQ, dstMD;
    logic [CNT_WID-1:0]  retiredQ, retiredD;
    logic                writeEn;
    logic                retire;

    // W register next state: stall beats bubble beats load
    always_comb begin
        statD = statQ;
        valED = valEQ;
        valMD = valMQ;
        dstED = dstEQ;
        dstMD = dstMQ;
        if (!W_stall) begin
            if (W_bubble) begin
                statD = STAT_BUB;
                valED = '0;
                valMD = '0;
                dstED = RNONE;
                dstMD = RNONE;
            end else begin
                statD = M_stat;
                valED = M_valE;
                valMD = M_valM;
                dstED = M_dstE;
                dstMD = M_dstM;
            end
        end
    end

    always_comb begin
        stateD = stateQ;
        if (stateQ == StRun) begin
            unique case (statQ)
                STAT_HLT:           stateD = StHalted;
                STAT_ADR, STAT_INS: stateD = StFault;
                default:            stateD = StRun;
            endcase
        end
    end

    assign writeEn  = (stateQ == StRun) && (statQ == STAT_AOK);
    assign retire   = writeEn && !W_stall;
    assign retiredD = retire ? retiredQ + CNT_WID'(1) : retiredQ;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stateQ   <= StRun;
            statQ    <= STAT_BUB;
            valEQ    <= '0;
            valMQ    <= '0;
            dstEQ    <= RNONE;
            dstMQ    <= RNONE;
            retiredQ <= '0;
        end else begin
            stateQ   <= stateD;
            statQ    <= statD;
            valEQ    <= valED;
            valMQ    <= valMD;
            dstEQ    <= dstED;
            dstMQ    <= dstMD;
            retiredQ <= retiredD;
        end
    end

    // Same destination on both ports: drop the E write so the memory value wins
    always_comb begin
        destE = RNONE;
        destM = RNONE;
        if (writeEn) begin
            destM = dstMQ;
            destE = (dstEQ == dstMQ && dstMQ != RNONE) ? RNONE : dstEQ;
        end
    end

    assign valE    = valEQ;
    assign valM    = valMQ;
    assign W_stat  = statQ;
    assign halted  = (stateQ == StHalted);
    assign fault   = (stateQ == StFault);
    assign retired = retiredQ;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomised and directed bench for writeback_stage, checked against a behavioural model
// of the W register, machine status and retire count.
module tb_writeback_stage;

    localparam logic [3:0] RN = 4'hF;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [2:0]  M_stat = 3'd0;
    logic [31:0] M_valE = '0;
    logic [31:0] M_valM = '0;
    logic [3:0]  M_dstE = RN;
    logic [3:0]  M_dstM = RN;
    logic        W_stall = 1'b0;
    logic        W_bubble = 1'b0;

    logic [31:0] valE, valM, retired;
    logic [3:0]  destE, destM;
    logic [2:0]  W_stat;
    logic        halted, fault;

    logic [31:0] nValE, nValM;
    logic [3:0]  nDestE, nDestM, nRetired;
    logic [2:0]  nStat;
    logic        nHalted, nFault;

    int nChecks = 0;
    int nFails  = 0;

    always #5 CLK = ~CLK;

    writeback_stage dut (
        .CLK(CLK), .RST(RST), .M_stat(M_stat), .M_valE(M_valE), .M_valM(M_valM),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .W_stall(W_stall), .W_bubble(W_bubble),
        .valE(valE), .valM(valM), .destE(destE), .destM(destM), .W_stat(W_stat),
        .halted(halted), .fault(fault), .retired(retired)
    );

    // Narrow counter build to exercise wrap-around on the same stimulus
    writeback_stage #(.CNT_WID(4)) dutNarrow (
        .CLK(CLK), .RST(RST), .M_stat(M_stat), .M_valE(M_valE), .M_valM(M_valM),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .W_stall(W_stall), .W_bubble(W_bubble),
        .valE(nValE), .valM(nValM), .destE(nDestE), .destM(nDestM), .W_stat(nStat),
        .halted(nHalted), .fault(nFault), .retired(nRetired)
    );

    // Model: the instruction sitting in W, whether the machine has stopped and why, and a count
    typedef struct {
        int unsigned stat;
        logic [31:0] valE;
        logic [31:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } instr_t;

    instr_t      mW;
    bit          mHalted, mFault;
    longint      mRet;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic instr_t bubbleInstr();
        instr_t b;
        b.stat = 0; b.valE = '0; b.valM = '0; b.dstE = RN; b.dstM = RN;
        return b;
    endfunction

    task automatic modelReset();
        mW = bubbleInstr();
        mHalted = 0;
        mFault = 0;
        mRet = 0;
    endtask

    task automatic checkAll(input string tag);
        bit writes;
        logic [3:0] eE, eM;
        writes = !mHalted && !mFault && mW.stat == 1;
        eE = RN;
        eM = RN;
        if (writes) begin
            eM = mW.dstM;
            eE = (mW.dstE != RN && mW.dstE == mW.dstM) ? RN : mW.dstE;
        end
        checkEq({tag, ".valE"}, 64'(valE), 64'(mW.valE));
        checkEq({tag, ".valM"}, 64'(valM), 64'(mW.valM));
        checkEq({tag, ".destE"}, 64'(destE), 64'(eE));
        checkEq({tag, ".destM"}, 64'(destM), 64'(eM));
        checkEq({tag, ".W_stat"}, 64'(W_stat), 64'(mW.stat));
        checkEq({tag, ".halted"}, 64'(halted), 64'(mHalted));
        checkEq({tag, ".fault"}, 64'(fault), 64'(mFault));
        checkEq({tag, ".retired"}, 64'(retired), 64'(mRet % (64'd1 << 32)));
        checkEq({tag, ".retired4"}, 64'(nRetired), 64'(mRet % 16));
    endtask

    task automatic drive(input int unsigned st, input logic [31:0] vE, input logic [31:0] vM,
                         input logic [3:0] dE, input logic [3:0] dM);
        M_stat = 3'(st);
        M_valE = vE;
        M_valM = vM;
        M_dstE = dE;
        M_dstM = dM;
    endtask

    // One clock: advance the model with the inputs present at the edge, then check outputs
    task automatic tick(input string tag);
        instr_t nxt;
        @(posedge CLK);
        if (!mHalted && !mFault) begin
            if (mW.stat == 1 && !W_stall) mRet++;
            if (mW.stat == 2) mHalted = 1;
            else if (mW.stat == 3 || mW.stat == 4) mFault = 1;
        end
        if (!W_stall) begin
            if (W_bubble) nxt = bubbleInstr();
            else begin
                nxt.stat = M_stat; nxt.valE = M_valE; nxt.valM = M_valM;
                nxt.dstE = M_dstE; nxt.dstM = M_dstM;
            end
            mW = nxt;
        end
        #1 checkAll(tag);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any clock
    task automatic midReset(input string tag);
        #2 RST = 1'b1;
        #1 modelReset();
        checkAll(tag);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        logic [31:0] holdE;
        modelReset();
        #2 checkAll("reset");
        @(negedge CLK);
        RST = 1'b0;

        drive(1, 32'h1234, 32'h0, 4'd2, RN);
        tick("load1");
        checkEq("load1.destE_const", 64'(destE), 64'd2);
        drive(0, 0, 0, RN, RN);
        tick("retire1");
        checkEq("retire1.count_const", 64'(retired), 64'd1);

        drive(1, 32'hAAAA, 32'hBBBB, 4'd5, 4'd5);
        tick("samedst");
        checkEq("samedst.destE_const", 64'(destE), 64'(RN));

        drive(1, 32'h6666, 32'h7777, 4'd6, 4'd7);
        tick("preStall");
        holdE = valE;
        W_stall = 1'b1;
        drive(1, 32'h9999, 32'h9999, 4'd9, 4'd9);
        for (int i = 0; i < 3; i++) begin
            tick("stall");
            checkEq("stall.valE_hold", 64'(valE), 64'(holdE));
        end
        W_stall = 1'b0;
        drive(0, 0, 0, RN, RN);
        tick("stallRelease");

        drive(2, 0, 0, RN, RN);
        tick("hltLoad");
        drive(1, 32'h3333, 0, 4'd3, RN);
        tick("halted");
        checkEq("halted.const", 64'(halted), 64'd1);
        for (int i = 0; i < 4; i++) tick("afterHalt");

        midReset("resetHalt");
        drive(3, 32'h4444, 0, 4'd4, RN);
        tick("adrLoad");
        drive(1, 32'h4444, 0, 4'd4, RN);
        tick("fault");
        checkEq("fault.const", 64'(fault), 64'd1);
        tick("faultHold");
        midReset("resetFault");
        checkEq("resetFault.retired_const", 64'(retired), 64'd0);

        for (int i = 0; i < 17; i++) begin
            drive(1, 32'(i), 32'(i + 100), 4'(i % 15), RN);
            tick("wrap");
        end
        drive(0, 0, 0, RN, RN);
        tick("wrapEnd");
        checkEq("wrap.narrow_const", 64'(nRetired), 64'd1);

        for (int i = 0; i < 600; i++) begin
            int unsigned r;
            int unsigned st;
            r = $urandom_range(0, 99);
            st = (r < 10) ? 0 : (r < 92) ? 1 : (r < 95) ? 2 : (r < 98) ? 3 : 4;
            drive(st, $urandom, $urandom, 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
            W_stall  = ($urandom_range(0, 99) < 20);
            W_bubble = ($urandom_range(0, 99) < 15);
            tick("rand");
            if ((mHalted || mFault) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 60) == 0))
                midReset("randReset");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
